// File: rtl/rob_ring_if.sv
// Signal bundle between the reorder buffer and its neighbours: decoder issue,
// RS/LSB writeback, operand lookup, commit, store handshake and redirect.
interface rob_ring_if #(
  parameter int IDX_W = 4,
  parameter int XLEN  = 32
);
  // Decoder issue
  logic             dec_valid;
  logic [1:0]       dec_type;
  logic [4:0]       dec_rd;
  logic [XLEN-1:0]  dec_val;
  logic [XLEN-1:0]  dec_pc;
  logic [XLEN-1:0]  dec_pred;
  logic [IDX_W-1:0] alloc_id;
  logic             rob_full;
  logic             rob_empty;

  // Writeback buses
  logic             rs_valid;
  logic [IDX_W-1:0] rs_id;
  logic [XLEN-1:0]  rs_val;
  logic             lsb_valid;
  logic [IDX_W-1:0] lsb_id;
  logic [XLEN-1:0]  lsb_val;

  // Operand lookup
  logic [IDX_W-1:0] srch_id_a;
  logic [IDX_W-1:0] srch_id_b;
  logic             srch_rdy_a;
  logic             srch_rdy_b;
  logic [XLEN-1:0]  srch_val_a;
  logic [XLEN-1:0]  srch_val_b;

  // Retire side
  logic             commit_valid;
  logic [IDX_W-1:0] commit_id;
  logic [4:0]       commit_rd;
  logic [XLEN-1:0]  commit_val;
  logic             st_commit_valid;
  logic             st_commit_ready;
  logic             flush;
  logic [XLEN-1:0]  redirect_pc;
  logic             jalr_busy;

  // Environment side: decoder, RS, LSB and regfile.
  modport master (
    output dec_valid, dec_type, dec_rd, dec_val, dec_pc, dec_pred,
    output rs_valid, rs_id, rs_val, lsb_valid, lsb_id, lsb_val,
    output srch_id_a, srch_id_b, st_commit_ready,
    input  alloc_id, rob_full, rob_empty,
    input  srch_rdy_a, srch_rdy_b, srch_val_a, srch_val_b,
    input  commit_valid, commit_id, commit_rd, commit_val,
    input  st_commit_valid, flush, redirect_pc, jalr_busy
  );

  // Reorder-buffer side.
  modport slave (
    input  dec_valid, dec_type, dec_rd, dec_val, dec_pc, dec_pred,
    input  rs_valid, rs_id, rs_val, lsb_valid, lsb_id, lsb_val,
    input  srch_id_a, srch_id_b, st_commit_ready,
    output alloc_id, rob_full, rob_empty,
    output srch_rdy_a, srch_rdy_b, srch_val_a, srch_val_b,
    output commit_valid, commit_id, commit_rd, commit_val,
    output st_commit_valid, flush, redirect_pc, jalr_busy
  );
endinterface

// File: rtl/rob_ring.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire,
// operand lookup with writeback bypass, and single-cycle mispredict flush.
module rob_ring #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int XLEN  = 32
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  rob_ring_if.slave bus
);

  typedef enum logic [1:0] {
    ET_BR   = 2'd0,
    ET_ST   = 2'd1,
    ET_JALR = 2'd2,
    ET_RG   = 2'd3
  } entry_type_e;

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  // Per-entry state: control bits are reset, payload is not.
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  entry_type_e      ent_type [DEPTH];
  logic [4:0]       ent_rd   [DEPTH];
  logic [XLEN-1:0]  ent_val  [DEPTH];
  logic [XLEN-1:0]  ent_pred [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic [IDX_W:0]   jalr_cnt;

  logic             commit_valid_q;
  logic [IDX_W-1:0] commit_id_q;
  logic [4:0]       commit_rd_q;
  logic [XLEN-1:0]  commit_val_q;
  logic             flush_q;
  logic [XLEN-1:0]  redirect_pc_q;

  entry_type_e dec_type;
  entry_type_e head_type;
  logic        head_ready;
  logic        rob_full;
  logic        retire;
  logic        mispredict;
  logic        issue;
  logic        rs_hit;
  logic        lsb_hit;
  logic        commit_now;
  logic        jalr_issue;
  logic        jalr_retire;

  assign dec_type   = entry_type_e'(bus.dec_type);
  assign head_type  = ent_type[head];
  assign head_ready = ent_valid[head] && ent_done[head];
  assign rob_full   = (count == FULL_CNT);

  // A done store at head only leaves once the LSB has taken it.
  assign retire      = rdy_in && head_ready &&
                       ((head_type != ET_ST) || bus.st_commit_ready);
  assign mispredict  = retire && (head_type == ET_BR) &&
                       (ent_val[head] != ent_pred[head]);
  assign issue       = rdy_in && bus.dec_valid && (!rob_full || retire) && !mispredict;
  assign rs_hit      = rdy_in && bus.rs_valid  && ent_valid[bus.rs_id];
  assign lsb_hit     = rdy_in && bus.lsb_valid && ent_valid[bus.lsb_id];
  assign commit_now  = retire && ((head_type == ET_RG) || (head_type == ET_JALR));
  assign jalr_issue  = issue  && (dec_type  == ET_JALR);
  assign jalr_retire = retire && (head_type == ET_JALR);

  // Control state and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ent_valid      <= '0;
      ent_done       <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      jalr_cnt       <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
      flush_q        <= 1'b0;
      redirect_pc_q  <= '0;
    end else if (rdy_in) begin
      commit_valid_q <= commit_now;
      flush_q        <= mispredict;
      if (commit_now) begin
        commit_id_q  <= head;
        commit_rd_q  <= ent_rd[head];
        commit_val_q <= ent_val[head];
      end

      if (mispredict) begin
        redirect_pc_q <= ent_val[head];
        ent_valid     <= '0;
        ent_done      <= '0;
        head          <= '0;
        tail          <= '0;
        count         <= '0;
        jalr_cnt      <= '0;
      end else begin
        if (rs_hit)  ent_done[bus.rs_id]  <= 1'b1;
        if (lsb_hit) ent_done[bus.lsb_id] <= 1'b1;
        if (retire) begin
          ent_valid[head] <= 1'b0;
          head            <= head + 1'b1;
        end
        // Issue comes last so a full-buffer reuse of the retiring slot wins.
        if (issue) begin
          ent_valid[tail] <= 1'b1;
          ent_done[tail]  <= 1'b0;
          tail            <= tail + 1'b1;
        end

        case ({issue, retire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase

        case ({jalr_issue, jalr_retire})
          2'b10:   jalr_cnt <= jalr_cnt + 1'b1;
          2'b01:   jalr_cnt <= jalr_cnt - 1'b1;
          default: jalr_cnt <= jalr_cnt;
        endcase
      end
    end
  end

  // NOTE: payload storage has no reset; valid/done gate every use of it, and
  // leaving it out of the reset tree lets it map onto plain RAM/flops.
  always_ff @(posedge clk_in) begin
    if (rs_hit)  ent_val[bus.rs_id]  <= bus.rs_val;
    if (lsb_hit) ent_val[bus.lsb_id] <= bus.lsb_val;
    if (issue) begin
      ent_type[tail] <= dec_type;
      ent_rd[tail]   <= bus.dec_rd;
      ent_val[tail]  <= bus.dec_val;
      ent_pred[tail] <= bus.dec_pred;
    end
  end

  // Lookup result {rdy, val}: live LSB, then live RS, then stored entry.
  function automatic logic [XLEN:0] lookup(input logic [IDX_W-1:0] id);
    logic [XLEN:0] res;
    if (bus.lsb_valid && (bus.lsb_id == id))
      res = {1'b1, bus.lsb_val};
    else if (bus.rs_valid && (bus.rs_id == id))
      res = {1'b1, bus.rs_val};
    else
      res = {ent_valid[id] && ent_done[id], ent_val[id]};
    return res;
  endfunction

  assign {bus.srch_rdy_a, bus.srch_val_a} = lookup(bus.srch_id_a);
  assign {bus.srch_rdy_b, bus.srch_val_b} = lookup(bus.srch_id_b);

  assign bus.alloc_id        = tail;
  assign bus.rob_full        = rob_full;
  assign bus.rob_empty       = (count == '0);
  assign bus.st_commit_valid = head_ready && (head_type == ET_ST);
  assign bus.jalr_busy       = (jalr_cnt != '0);
  assign bus.commit_valid    = commit_valid_q;
  assign bus.commit_id       = commit_id_q;
  assign bus.commit_rd       = commit_rd_q;
  assign bus.commit_val      = commit_val_q;
  assign bus.flush           = flush_q;
  assign bus.redirect_pc     = redirect_pc_q;

  // Redirects come from the resolved branch value, so the issue PC is not kept.
  logic unused_dec_pc;
  assign unused_dec_pc = ^bus.dec_pc;

endmodule

// File: tb/tb_rob_ring.sv
// Self-checking bench for rob_ring: scenario tasks with inline comparisons and
// a commit scoreboard filled at issue time and drained by a commit monitor.
module tb_rob_ring;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int XLEN  = 32;

  localparam logic [1:0] T_BR = 2'd0, T_ST = 2'd1, T_JALR = 2'd2, T_RG = 2'd3;

  typedef struct packed {
    logic [IDX_W-1:0] id;
    logic [4:0]       rd;
    logic [XLEN-1:0]  val;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  rob_ring_if #(.IDX_W(IDX_W), .XLEN(XLEN)) bus ();

  rob_ring #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  exp_t             sb[$];
  int               vectors = 0;
  int               errors  = 0;
  logic [IDX_W-1:0] tb_tail = '0;

  // Commit monitor: a pulse is consumed on a cycle where rdy_in is high.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in && rdy_in && bus.commit_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got id=%0d rd=%0d val=%h, want no commit",
                 bus.commit_id, bus.commit_rd, bus.commit_val);
      end else begin
        e = sb.pop_front();
        if ({bus.commit_id, bus.commit_rd, bus.commit_val} !== e) begin
          errors++;
          $display("FAIL commit_order: got id=%0d rd=%0d val=%h, want id=%0d rd=%0d val=%h",
                   bus.commit_id, bus.commit_rd, bus.commit_val, e.id, e.rd, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    bus.dec_valid = 1'b0; bus.dec_type = T_RG; bus.dec_rd = '0;
    bus.dec_val = '0; bus.dec_pc = '0; bus.dec_pred = '0;
    bus.rs_valid = 1'b0; bus.rs_id = '0; bus.rs_val = '0;
    bus.lsb_valid = 1'b0; bus.lsb_id = '0; bus.lsb_val = '0;
    bus.srch_id_a = '0; bus.srch_id_b = '0; bus.st_commit_ready = 1'b0;
  endtask

  // Issue one entry for one cycle; 'fin' is the value the test will later write back.
  task automatic issue(input logic [1:0] typ, input logic [4:0] rd, input logic [XLEN-1:0] pred,
                       input logic [XLEN-1:0] fin, input bit accept, input bit push);
    bus.dec_valid = 1'b1; bus.dec_type = typ; bus.dec_rd = rd;
    bus.dec_val = ~fin; bus.dec_pc = 32'h4000 + 32'(tb_tail); bus.dec_pred = pred;
    if (accept) begin
      if (push) sb.push_back(exp_t'{id: tb_tail, rd: rd, val: fin});
      tb_tail++;
    end
    tick();
    bus.dec_valid = 1'b0;
    vectors++;
    if (bus.alloc_id !== tb_tail) begin
      errors++;
      $display("FAIL issue_alloc_id: got %0d want %0d", bus.alloc_id, tb_tail);
    end
  endtask

  task automatic rs_wb(input logic [IDX_W-1:0] id, input logic [XLEN-1:0] val);
    bus.rs_valid = 1'b1; bus.rs_id = id; bus.rs_val = val;
    tick();
    bus.rs_valid = 1'b0;
  endtask

  task automatic lsb_wb(input logic [IDX_W-1:0] id, input logic [XLEN-1:0] val);
    bus.lsb_valid = 1'b1; bus.lsb_id = id; bus.lsb_val = val;
    tick();
    bus.lsb_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(bus.rob_empty && sb.size() == 0) && n < 64) begin
      tick();
      n++;
    end
    vectors++;
    if (!(bus.rob_empty && sb.size() == 0)) begin
      errors++;
      $display("FAIL %s_drain: got empty=%b pending=%0d after %0d cycles, want empty=1 pending=0",
               tag, bus.rob_empty, sb.size(), n);
    end
  endtask

  task automatic apply_reset();
    rst_in = 1'b0;
    #1;
    tick();
    rst_in = 1'b1;
    tb_tail = '0;
    sb.delete();
  endtask

  // Everything the reset must clear, observed without a clock edge.
  task automatic test_reset_outputs(input string tag);
    vectors++;
    if ({bus.commit_valid, bus.commit_id, bus.commit_rd, bus.commit_val} !== '0) begin
      errors++;
      $display("FAIL %s_commit: got v=%b id=%0d rd=%0d val=%h want all 0", tag,
               bus.commit_valid, bus.commit_id, bus.commit_rd, bus.commit_val);
    end
    vectors++;
    if ({bus.flush, bus.redirect_pc} !== '0) begin
      errors++;
      $display("FAIL %s_flush: got flush=%b pc=%h want 0/0", tag, bus.flush, bus.redirect_pc);
    end
    vectors++;
    if ({bus.alloc_id, bus.rob_full, bus.rob_empty} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s_ptrs: got alloc=%0d full=%b empty=%b want 0/0/1", tag,
               bus.alloc_id, bus.rob_full, bus.rob_empty);
    end
    vectors++;
    if ({bus.jalr_busy, bus.st_commit_valid, bus.srch_rdy_a, bus.srch_rdy_b} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_flags: got jalr=%b st=%b rdy_a=%b rdy_b=%b want 0000", tag,
               bus.jalr_busy, bus.st_commit_valid, bus.srch_rdy_a, bus.srch_rdy_b);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_in = 1'b0;
    #2;
    test_reset_outputs("reset");
    tick();
    tick();
    test_reset_outputs("reset_held");
    rst_in = 1'b1;
    tb_tail = '0;
  endtask

  task automatic test_inorder_commit();
    issue(T_RG, 5'd1, '0, 32'hB, 1, 1);
    issue(T_RG, 5'd2, '0, 32'hC, 1, 1);
    issue(T_RG, 5'd3, '0, 32'hA, 1, 1);
    rs_wb(4'd2, 32'hA);
    vectors++;
    if (bus.commit_valid !== 1'b0) begin
      errors++; $display("FAIL inorder_early: got commit_valid=%b want 0", bus.commit_valid);
    end
    rs_wb(4'd0, 32'hB);
    rs_wb(4'd1, 32'hC);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.commit_valid !== 1'b1) begin
        errors++; $display("FAIL inorder_pulse%0d: got commit_valid=%b want 1", i, bus.commit_valid);
      end
      tick();
    end
    vectors++;
    if (bus.commit_valid !== 1'b0 || bus.rob_empty !== 1'b1) begin
      errors++;
      $display("FAIL inorder_end: got commit_valid=%b empty=%b want 0/1", bus.commit_valid, bus.rob_empty);
    end
    drain("inorder");
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) issue(T_RG, 5'(i + 1), '0, 32'h1000 + i, 1, 1);
    vectors++;
    if ({bus.rob_full, bus.rob_empty, bus.alloc_id} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL full_flags: got full=%b empty=%b alloc=%0d want 1/0/0",
               bus.rob_full, bus.rob_empty, bus.alloc_id);
    end
    // Issue while full and nothing retiring must be ignored.
    issue(T_RG, 5'd30, '0, 32'hBAD, 0, 0);
    rs_wb(4'd0, 32'h1000);
    // Retire id0 and issue into its slot on the same edge.
    issue(T_RG, 5'd9, '0, 32'h2000, 1, 1);
    vectors++;
    if (bus.rob_full !== 1'b1) begin
      errors++; $display("FAIL full_swap: got full=%b want 1", bus.rob_full);
    end
    for (int i = 1; i < DEPTH; i++) rs_wb(IDX_W'(i), 32'h1000 + i);
    rs_wb(4'd0, 32'h2000);
    drain("full");
  endtask

  task automatic test_store_commit();
    issue(T_ST, 5'd0, '0, '0, 1, 0);
    issue(T_RG, 5'd7, '0, 32'h3333, 1, 1);
    lsb_wb(4'd1, 32'hDEAD);
    rs_wb(4'd2, 32'h3333);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus.st_commit_valid, bus.commit_valid, bus.alloc_id, bus.rob_empty} !== {1'b1, 1'b0, 4'd3, 1'b0}) begin
        errors++;
        $display("FAIL store_wait%0d: got st=%b commit=%b alloc=%0d empty=%b want 1/0/3/0", i,
                 bus.st_commit_valid, bus.commit_valid, bus.alloc_id, bus.rob_empty);
      end
      tick();
    end
    bus.st_commit_ready = 1'b1;
    tick();
    bus.st_commit_ready = 1'b0;
    vectors++;
    if ({bus.st_commit_valid, bus.commit_valid} !== 2'b00) begin
      errors++;
      $display("FAIL store_retire: got st=%b commit=%b want 0/0", bus.st_commit_valid, bus.commit_valid);
    end
    drain("store");
  endtask

  task automatic test_mispredict();
    issue(T_BR,   5'd0, 32'h100, 32'h200, 1, 0);
    issue(T_RG,   5'd4, '0, 32'h1, 1, 0);
    issue(T_JALR, 5'd5, '0, 32'h2, 1, 0);
    issue(T_RG,   5'd6, '0, 32'h3, 1, 0);
    issue(T_RG,   5'd7, '0, 32'h4, 1, 0);
    vectors++;
    if (bus.jalr_busy !== 1'b1) begin
      errors++; $display("FAIL br_jalr_before: got jalr_busy=%b want 1", bus.jalr_busy);
    end
    rs_wb(4'd3, 32'h200);
    // Same-cycle issue and writeback are discarded by the flush.
    bus.dec_valid = 1'b1; bus.dec_type = T_RG; bus.dec_rd = 5'd8;
    bus.lsb_valid = 1'b1; bus.lsb_id = 4'd4; bus.lsb_val = 32'h99;
    tick();
    clear_inputs();
    tb_tail = '0;
    vectors++;
    if ({bus.flush, bus.redirect_pc} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL br_flush: got flush=%b pc=%h want 1/00000200", bus.flush, bus.redirect_pc);
    end
    vectors++;
    if ({bus.rob_empty, bus.alloc_id, bus.jalr_busy, bus.commit_valid} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL br_state: got empty=%b alloc=%0d jalr=%b commit=%b want 1/0/0/0",
               bus.rob_empty, bus.alloc_id, bus.jalr_busy, bus.commit_valid);
    end
    tick();
    vectors++;
    if ({bus.flush, bus.rob_empty} !== 2'b01) begin
      errors++; $display("FAIL br_pulse: got flush=%b empty=%b want 0/1", bus.flush, bus.rob_empty);
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 4; i++) issue(T_RG, 5'(10 + i), '0, 32'h500 + i, 1, 1);
    issue(T_RG, 5'd14, '0, 32'h44, 1, 1);
    issue(T_RG, 5'd15, '0, 32'h77, 1, 1);
    bus.srch_id_a = 4'd5; bus.srch_id_b = 4'd4;
    bus.rs_valid = 1'b1;  bus.rs_id = 4'd5;  bus.rs_val = 32'h55;
    bus.lsb_valid = 1'b1; bus.lsb_id = 4'd5; bus.lsb_val = 32'h77;
    #1;
    vectors++;
    if ({bus.srch_rdy_a, bus.srch_val_a, bus.srch_rdy_b} !== {1'b1, 32'h77, 1'b0}) begin
      errors++;
      $display("FAIL bypass_both: got rdy_a=%b val_a=%h rdy_b=%b want 1/00000077/0",
               bus.srch_rdy_a, bus.srch_val_a, bus.srch_rdy_b);
    end
    tick();
    bus.rs_valid = 1'b0; bus.lsb_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.srch_rdy_a, bus.srch_val_a} !== {1'b1, 32'h77}) begin
      errors++;
      $display("FAIL bypass_stored: got rdy_a=%b val_a=%h want 1/00000077", bus.srch_rdy_a, bus.srch_val_a);
    end
    bus.rs_valid = 1'b1; bus.rs_id = 4'd4; bus.rs_val = 32'h44;
    #1;
    vectors++;
    if ({bus.srch_rdy_b, bus.srch_val_b} !== {1'b1, 32'h44}) begin
      errors++;
      $display("FAIL bypass_rs: got rdy_b=%b val_b=%h want 1/00000044", bus.srch_rdy_b, bus.srch_val_b);
    end
    tick();
    bus.rs_valid = 1'b0;
    for (int i = 0; i < 4; i++) lsb_wb(IDX_W'(i), 32'h500 + i);
    drain("bypass");
  endtask

  task automatic test_jalr_stall();
    issue(T_JALR, 5'd20, '0, 32'h6000, 1, 1);
    vectors++;
    if (bus.jalr_busy !== 1'b1) begin
      errors++; $display("FAIL jalr_busy_set: got %b want 1", bus.jalr_busy);
    end
    rdy_in = 1'b0;
    bus.rs_valid = 1'b1; bus.rs_id = 4'd6; bus.rs_val = 32'h9999;
    bus.dec_valid = 1'b1; bus.dec_type = T_RG;
    tick();
    tick();
    clear_inputs();
    bus.srch_id_a = 4'd6;
    #1;
    vectors++;
    if ({bus.alloc_id, bus.jalr_busy, bus.rob_empty, bus.srch_rdy_a} !== {4'd7, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stall_hold: got alloc=%0d jalr=%b empty=%b rdy_a=%b want 7/1/0/0",
               bus.alloc_id, bus.jalr_busy, bus.rob_empty, bus.srch_rdy_a);
    end
    rdy_in = 1'b1;
    rs_wb(4'd6, 32'h6000);
    tick();
    vectors++;
    if ({bus.commit_valid, bus.jalr_busy} !== 2'b10) begin
      errors++; $display("FAIL jalr_retire: got commit=%b jalr=%b want 1/0", bus.commit_valid, bus.jalr_busy);
    end
    rdy_in = 1'b0;
    tick();
    vectors++;
    if (bus.commit_valid !== 1'b1) begin
      errors++; $display("FAIL stall_pulse_hold: got commit_valid=%b want 1", bus.commit_valid);
    end
    rdy_in = 1'b1;
    tick();
    vectors++;
    if ({bus.commit_valid, bus.rob_empty} !== 2'b01) begin
      errors++; $display("FAIL stall_pulse_clear: got commit=%b empty=%b want 0/1", bus.commit_valid, bus.rob_empty);
    end
    drain("jalr");
  endtask

  task automatic test_midrun_reset();
    issue(T_RG,   5'd21, '0, 32'h7777, 1, 1);
    issue(T_JALR, 5'd22, '0, 32'h8888, 1, 0);
    rs_wb(4'd7, 32'h7777);
    tick();
    vectors++;
    if ({bus.commit_valid, bus.jalr_busy} !== 2'b11) begin
      errors++; $display("FAIL midrun_pre: got commit=%b jalr=%b want 1/1", bus.commit_valid, bus.jalr_busy);
    end
    #2;
    rst_in = 1'b0;
    #1;
    test_reset_outputs("midrun");
    sb.delete();
    tick();
    rst_in = 1'b1;
    tb_tail = '0;
  endtask

  initial begin
    test_reset();
    test_inorder_commit();
    test_full();
    test_store_commit();
    test_mispredict();
    test_bypass();
    test_jalr_stall();
    test_midrun_reset();
    vectors++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
